// File: rtl/cache_way_if.sv
// CPU-side and memory-side signal bundle for the 2-way cache controller.
// master = CPU/memory environment, slave = the controller.
interface cache_way_if #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_WIDTH = 32
);
  // Memory handshake: mem_req stays high until a one-cycle mem_ack,
  // and mem_rdata is valid in the mem_ack cycle.
  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  flush;
  logic                  cpu_ready;
  logic                  cpu_busy;
  logic                  hit1;
  logic [INDEX_BITS-1:0] set_index;
  logic                  we_way0;
  logic                  we_way1;
  logic [31:0]           fill_data;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    input  cpu_ready, cpu_busy, hit1, set_index, we_way0, we_way1,
           fill_data, mem_req, mem_addr
  );

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    output cpu_ready, cpu_busy, hit1, set_index, we_way0, we_way1,
           fill_data, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_way_controller.sv
// Tag/valid/LRU owner and sequencer for a 2-way set-associative cache with
// single-word refill over a req/ack memory handshake.
module cache_way_controller #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  cache_way_if.slave bus,
  output logic [1:0] dbg_state_o
);
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, REFILL, WRITE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  victim_q;
  logic                  hit1_q;
  logic [31:0]           fill_q;
  logic [SETS-1:0]       valid0_q, valid1_q, lru_q;
  logic [TAG_BITS-1:0]   tag0_q [SETS];
  logic [TAG_BITS-1:0]   tag1_q [SETS];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit_w0, hit_w1, any_hit, victim_d;
  logic                  cpu_ready, hit1, we0, we1, mem_req;

  assign idx     = addr_q[INDEX_BITS+1:2];
  assign tag     = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit_w0  = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit_w1  = valid1_q[idx] && (tag1_q[idx] == tag);
  assign any_hit = hit_w0 || hit_w1;
  // Fill empty ways first (way0 before way1); only then evict the LRU way.
  assign victim_d = !valid0_q[idx] ? 1'b0 :
                    !valid1_q[idx] ? 1'b1 : lru_q[idx];

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    hit1      = hit1_q;
    we0       = 1'b0;
    we1       = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.cpu_req) state_d = COMPARE;
      end
      COMPARE: begin
        if (any_hit) begin
          cpu_ready = 1'b1;
          hit1      = !hit_w0;
          state_d   = IDLE;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        if (bus.mem_ack) state_d = WRITE;
      end
      WRITE: begin
        we0     = !victim_q;
        we1     = victim_q;
        state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      victim_q <= 1'b0;
      hit1_q   <= 1'b0;
      fill_q   <= '0;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.flush) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
          end else if (bus.cpu_req) begin
            addr_q <= bus.cpu_addr;
          end
        end
        COMPARE: begin
          if (any_hit) begin
            hit1_q     <= !hit_w0;
            lru_q[idx] <= hit_w0;  // the way not hit becomes LRU
          end else begin
            victim_q <= victim_d;
          end
        end
        REFILL: begin
          if (bus.mem_ack) fill_q <= bus.mem_rdata;
        end
        WRITE: begin
          if (victim_q) valid1_q[idx] <= 1'b1;
          else          valid0_q[idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tags need no reset: they are only trusted when the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) begin
      if (victim_q) tag1_q[idx] <= tag;
      else          tag0_q[idx] <= tag;
    end
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_busy  = (state_q != IDLE);
  assign bus.hit1      = hit1;
  assign bus.set_index = idx;
  assign bus.we_way0   = we0;
  assign bus.we_way1   = we1;
  assign bus.fill_data = fill_q;
  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dbg_state_o   = state_q;
endmodule
